// File: rtl/mask_sched_if.sv
// Request, mask-write and lane-mask beat signals of mask_sched, grouped as one bundle.
// The slave modport is the scheduler; the master modport is its environment.
interface mask_sched_if #(
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned VLMAX     = 32
);
    localparam int unsigned VLW = $clog2(VLMAX + 1);
    localparam int unsigned BW  = $clog2(VLMAX / NUM_LANES);

    logic [1:0]                req_valid;
    logic [1:0]                req_ready;
    logic [1:0][VLW-1:0]       req_vl;
    logic [1:0]                req_vm;
    logic                      mwr_en;
    logic [VLMAX-1:0]          mwr_data;
    logic                      mwr_ready;
    logic                      beat_valid;
    logic                      beat_ready;
    logic [NUM_LANES-1:0]      beat_mask;
    logic [BW-1:0]             beat_idx;
    logic                      beat_last;
    logic                      beat_owner;
    logic [1:0]                done;

    modport master (
        output req_valid, req_vl, req_vm, mwr_en, mwr_data, beat_ready,
        input  req_ready, mwr_ready, beat_valid, beat_mask, beat_idx, beat_last,
               beat_owner, done
    );

    modport slave (
        input  req_valid, req_vl, req_vm, mwr_en, mwr_data, beat_ready,
        output req_ready, mwr_ready, beat_valid, beat_mask, beat_idx, beat_last,
               beat_owner, done
    );
endinterface

// File: rtl/mask_sched.sv
// Lane-mask beat scheduler: round-robin arbitration of two vector requesters, then per-beat lane enables.
// Build macro MASKSCHED_SKIP_EN suppresses all-zero non-last beats (one index per cycle while skipping).
module mask_sched #(
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned VLMAX     = 32
) (
    input  logic        clk,
    input  logic        rst,
    mask_sched_if.slave bus
);
    localparam int unsigned VLW = $clog2(VLMAX + 1);
    localparam int unsigned BW  = $clog2(VLMAX / NUM_LANES);
    localparam int unsigned LW  = $clog2(NUM_LANES);
    localparam int unsigned EW  = BW + LW;
    localparam int unsigned CW  = VLW + 1;

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t                state_q, state_n;
    logic [VLMAX-1:0]      mreg_q, mreg_n;
    logic                  rr_q, rr_n;
    logic [VLW-1:0]        vl_q, vl_n;
    logic                  vm_q, vm_n;
    logic                  owner_q, owner_n;
    logic [BW-1:0]         idx_q, idx_n;
    logic                  bv_q, bv_n;
    logic [NUM_LANES-1:0]  bm_q, bm_n;
    logic                  bl_q, bl_n;
    logic [1:0]            done_q, done_n;

    logic                  gnt_any;
    logic                  gnt;
    logic [BW-1:0]         cand_idx;
    logic [VLW-1:0]        cand_vl;
    logic                  cand_vm;
    logic [NUM_LANES-1:0]  cand_mask;
    logic                  cand_last;
    logic                  cand_show;

    // Lane j of beat i is enabled when its element lies below vl and, if masked, its mask bit is set.
    function automatic logic [NUM_LANES-1:0] lane_mask(input logic [BW-1:0] i,
                                                       input logic [VLW-1:0] vl,
                                                       input logic vm,
                                                       input logic [VLMAX-1:0] m);
        logic [NUM_LANES-1:0] r;
        logic [EW-1:0]        e;
        r = '0;
        for (int j = 0; j < int'(NUM_LANES); j++) begin
            e    = {i, LW'(j)};
            r[j] = (CW'(e) < CW'(vl)) && (!vm || m[e]);
        end
        return r;
    endfunction

    function automatic logic is_last(input logic [BW-1:0] i, input logic [VLW-1:0] vl);
        logic [CW-1:0] nb;
        nb = (CW'(vl) + CW'(NUM_LANES - 1)) >> LW;
        return CW'(i) == (nb - CW'(1));
    endfunction

    // A pending mask write blocks the grant for this cycle.
    assign gnt_any = (state_q == IDLE) && !bus.mwr_en && (|bus.req_valid) && !rst;
    assign gnt     = bus.req_valid[rr_q] ? rr_q : ~rr_q;

    assign bus.req_ready  = {gnt_any & gnt, gnt_any & ~gnt};
    assign bus.mwr_ready  = (state_q == IDLE) && !rst;
    assign bus.beat_valid = bv_q;
    assign bus.beat_mask  = bm_q;
    assign bus.beat_idx   = idx_q;
    assign bus.beat_last  = bl_q;
    assign bus.beat_owner = owner_q;
    assign bus.done       = done_q;

    // Candidate beat: index 0 of the granted request in IDLE, the following index in ISSUE.
    always_comb begin
        cand_idx = '0;
        cand_vl  = vl_q;
        cand_vm  = vm_q;
        if (state_q == ISSUE) begin
            cand_idx = idx_q + BW'(1);
        end else begin
            cand_vl = bus.req_vl[gnt];
            cand_vm = bus.req_vm[gnt];
        end
        cand_mask = lane_mask(cand_idx, cand_vl, cand_vm, mreg_q);
        cand_last = is_last(cand_idx, cand_vl);
`ifdef MASKSCHED_SKIP_EN
        cand_show = cand_last || (|cand_mask);
`else
        cand_show = 1'b1;
`endif
    end

    always_comb begin
        state_n = state_q;
        mreg_n  = mreg_q;
        rr_n    = rr_q;
        vl_n    = vl_q;
        vm_n    = vm_q;
        owner_n = owner_q;
        idx_n   = idx_q;
        bv_n    = bv_q;
        bm_n    = bm_q;
        bl_n    = bl_q;
        done_n  = '0;
        unique case (state_q)
            IDLE: begin
                if (bus.mwr_en) begin
                    mreg_n = bus.mwr_data;
                end else if (gnt_any) begin
                    vl_n    = cand_vl;
                    vm_n    = cand_vm;
                    owner_n = gnt;
                    rr_n    = ~gnt;
                    if (cand_vl == '0) begin
                        done_n[gnt] = 1'b1;
                    end else begin
                        state_n = ISSUE;
                        idx_n   = '0;
                        bv_n    = cand_show;
                        bm_n    = cand_mask;
                        bl_n    = cand_last;
                    end
                end
            end
            ISSUE: begin
                // Advance when the current beat is consumed or was suppressed.
                if (!bv_q || bus.beat_ready) begin
                    if (bv_q && bl_q) begin
                        state_n         = IDLE;
                        bv_n            = 1'b0;
                        done_n[owner_q] = 1'b1;
                    end else begin
                        idx_n = cand_idx;
                        bv_n  = cand_show;
                        bm_n  = cand_mask;
                        bl_n  = cand_last;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mreg_q  <= '0;
            rr_q    <= 1'b0;
            vl_q    <= '0;
            vm_q    <= 1'b0;
            owner_q <= 1'b0;
            idx_q   <= '0;
            bv_q    <= 1'b0;
            bm_q    <= '0;
            bl_q    <= 1'b0;
            done_q  <= '0;
        end else begin
            state_q <= state_n;
            mreg_q  <= mreg_n;
            rr_q    <= rr_n;
            vl_q    <= vl_n;
            vm_q    <= vm_n;
            owner_q <= owner_n;
            idx_q   <= idx_n;
            bv_q    <= bv_n;
            bm_q    <= bm_n;
            bl_q    <= bl_n;
            done_q  <= done_n;
        end
    end
endmodule

// File: tb/tb_mask_sched.sv
// Scoreboard bench for mask_sched: directed stimulus pushes hand-computed beats/done pulses,
// independent monitors pop and compare whenever the DUT hands a beat or pulses done.
module tb_mask_sched;
    localparam int unsigned NUM_LANES = 4;
    localparam int unsigned VLMAX     = 32;
    localparam int unsigned VLW       = $clog2(VLMAX + 1);

    typedef struct packed {
        logic       owner;
        logic [2:0] idx;
        logic [3:0] mask;
        logic       last;
    } beat_t;

    logic clk = 1'b0;
    logic rst;

    mask_sched_if #(.NUM_LANES(NUM_LANES), .VLMAX(VLMAX)) bus ();

    mask_sched #(.NUM_LANES(NUM_LANES), .VLMAX(VLMAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_fail   = 0;
    beat_t exp_beats[$];
    logic [1:0] exp_done[$];
    beat_t mon_b;
    logic [1:0] mon_d;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_beat(input logic owner, input int idx, input logic [3:0] mask, input logic last);
        beat_t b;
        b.owner = owner;
        b.idx   = 3'(idx);
        b.mask  = mask;
        b.last  = last;
        exp_beats.push_back(b);
    endtask

    // Beat monitor: every handshake must match the next expected beat.
    always @(negedge clk) begin
        if (!rst && bus.beat_valid && bus.beat_ready) begin
            if (exp_beats.size() == 0) begin
                chk("beat_unexpected", 64'(bus.beat_valid), 64'(0));
            end else begin
                mon_b = exp_beats.pop_front();
                chk("beat_mask",  64'(bus.beat_mask),  64'(mon_b.mask));
                chk("beat_idx",   64'(bus.beat_idx),   64'(mon_b.idx));
                chk("beat_last",  64'(bus.beat_last),  64'(mon_b.last));
                chk("beat_owner", 64'(bus.beat_owner), 64'(mon_b.owner));
            end
        end
    end

    // Done monitor: pulses must arrive in the expected order.
    always @(negedge clk) begin
        if (!rst && bus.done != 2'b00) begin
            if (exp_done.size() == 0) begin
                chk("done_unexpected", 64'(bus.done), 64'(0));
            end else begin
                mon_d = exp_done.pop_front();
                chk("done_pulse", 64'(bus.done), 64'(mon_d));
            end
        end
    end

    task automatic wait_ready(input logic [1:0] want, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.req_ready != want && n < 40);
        chk(name, 64'(bus.req_ready), 64'(want));
    endtask

    task automatic issue(input int r, input int vl, input logic vm);
        @(posedge clk); #1;
        bus.req_valid[r] = 1'b1;
        bus.req_vl[r]    = VLW'(vl);
        bus.req_vm[r]    = vm;
        wait_ready((r != 0) ? 2'b10 : 2'b01, "req_ready_grant");
        @(posedge clk); #1;
        bus.req_valid[r] = 1'b0;
    endtask

    task automatic write_mask(input logic [VLMAX-1:0] data);
        @(posedge clk); #1;
        bus.mwr_en   = 1'b1;
        bus.mwr_data = data;
        @(negedge clk);
        chk("mwr_ready", 64'(bus.mwr_ready), 64'(1));
        @(posedge clk); #1;
        bus.mwr_en = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_beats.size() != 0 || exp_done.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(exp_beats.size() + exp_done.size()), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst            = 1'b1;
        bus.req_valid  = 2'b11;
        bus.req_vl[0]  = VLW'(4);
        bus.req_vl[1]  = VLW'(4);
        bus.req_vm     = 2'b00;
        bus.mwr_en     = 1'b0;
        bus.mwr_data   = '0;
        bus.beat_ready = 1'b1;

        // Reset state, with both requests already asserted.
        repeat (2) @(negedge clk);
        chk("rst_req_ready",  64'(bus.req_ready),  64'(0));
        chk("rst_beat_valid", 64'(bus.beat_valid), 64'(0));
        chk("rst_beat_mask",  64'(bus.beat_mask),  64'(0));
        chk("rst_beat_idx",   64'(bus.beat_idx),   64'(0));
        chk("rst_beat_last",  64'(bus.beat_last),  64'(0));
        chk("rst_beat_owner", 64'(bus.beat_owner), 64'(0));
        chk("rst_done",       64'(bus.done),       64'(0));

        // Both requesters after reset: 0 first, then 1.
        push_beat(1'b0, 0, 4'hF, 1'b1);
        push_beat(1'b1, 0, 4'hF, 1'b1);
        exp_done.push_back(2'b01);
        exp_done.push_back(2'b10);
        @(posedge clk); #1;
        rst = 1'b0;
        wait_ready(2'b01, "rr_first_grant");
        @(posedge clk); #1;
        bus.req_valid = 2'b10;
        wait_ready(2'b10, "rr_second_grant");
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        drain("drain_rr");

        // Unmasked vl=10.
        push_beat(1'b0, 0, 4'hF, 1'b0);
        push_beat(1'b0, 1, 4'hF, 1'b0);
        push_beat(1'b0, 2, 4'h3, 1'b1);
        exp_done.push_back(2'b01);
        issue(0, 10, 1'b0);
        drain("drain_unmasked");

        // Masked vl=8 with mreg=A5A5_A5A5.
        write_mask(32'hA5A5_A5A5);
        push_beat(1'b1, 0, 4'h5, 1'b0);
        push_beat(1'b1, 1, 4'hA, 1'b1);
        exp_done.push_back(2'b10);
        issue(1, 8, 1'b1);
        drain("drain_masked");

        // Back-pressure on idx 1 for three cycles.
        push_beat(1'b0, 0, 4'hF, 1'b0);
        push_beat(1'b0, 1, 4'hF, 1'b0);
        push_beat(1'b0, 2, 4'h3, 1'b1);
        exp_done.push_back(2'b01);
        bus.beat_ready = 1'b0;
        issue(0, 10, 1'b0);
        bus.beat_ready = 1'b1;
        @(posedge clk); #1;
        bus.beat_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_valid", 64'(bus.beat_valid), 64'(1));
            chk("bp_mask",  64'(bus.beat_mask),  64'(4'hF));
            chk("bp_idx",   64'(bus.beat_idx),   64'(1));
            chk("bp_owner", 64'(bus.beat_owner), 64'(0));
        end
        @(posedge clk); #1;
        bus.beat_ready = 1'b1;
        drain("drain_bp");

        // vl=0: no beat, one done pulse.
        exp_done.push_back(2'b10);
        issue(1, 0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("vl0_no_beat", 64'(bus.beat_valid), 64'(0));
        end
        drain("drain_vl0");

        // Write and request in the same IDLE cycle: write wins, grant uses the new mask.
`ifdef MASKSCHED_SKIP_EN
        push_beat(1'b0, 1, 4'hF, 1'b1);
`else
        push_beat(1'b0, 0, 4'h0, 1'b0);
        push_beat(1'b0, 1, 4'hF, 1'b1);
`endif
        exp_done.push_back(2'b01);
        @(posedge clk); #1;
        bus.mwr_en       = 1'b1;
        bus.mwr_data     = 32'h0000_00F0;
        bus.req_valid[0] = 1'b1;
        bus.req_vl[0]    = VLW'(8);
        bus.req_vm[0]    = 1'b1;
        @(negedge clk);
        chk("collide_req_ready", 64'(bus.req_ready), 64'(0));
        chk("collide_mwr_ready", 64'(bus.mwr_ready), 64'(1));
        @(posedge clk); #1;
        bus.mwr_en = 1'b0;
        wait_ready(2'b01, "collide_grant_next");
        @(posedge clk); #1;
        bus.req_valid[0] = 1'b0;
        drain("drain_collide");

        // Full-length vl=VLMAX with mreg=0000_F000.
        write_mask(32'h0000_F000);
`ifdef MASKSCHED_SKIP_EN
        push_beat(1'b0, 3, 4'hF, 1'b0);
        push_beat(1'b0, 7, 4'h0, 1'b1);
`else
        for (int i = 0; i < 8; i++) push_beat(1'b0, i, (i == 3) ? 4'hF : 4'h0, i == 7);
`endif
        exp_done.push_back(2'b01);
        issue(0, 32, 1'b1);
        drain("drain_vlmax");

        // Reset mid-ISSUE aborts with no done pulse.
        bus.beat_ready = 1'b0;
        issue(1, 32, 1'b0);
        @(negedge clk);
        chk("abort_in_issue", 64'(bus.beat_valid), 64'(1));
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_beat_valid", 64'(bus.beat_valid), 64'(0));
        chk("abort_beat_mask",  64'(bus.beat_mask),  64'(0));
        chk("abort_beat_last",  64'(bus.beat_last),  64'(0));
        chk("abort_beat_owner", 64'(bus.beat_owner), 64'(0));
        chk("abort_done",       64'(bus.done),       64'(0));
        chk("abort_req_ready",  64'(bus.req_ready),  64'(0));
        @(posedge clk); #1;
        rst            = 1'b0;
        bus.beat_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post_abort_valid", 64'(bus.beat_valid), 64'(0));
            chk("post_abort_done",  64'(bus.done),       64'(0));
        end

        chk("queues_empty", 64'(exp_beats.size() + exp_done.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
